// File: rtl/dlx_pkg.sv
// dlx_pkg: shared types and constants for the DLX fetch/decode boundary.
//   PC_STEP       - byte distance between sequential instructions
//   fetch_entry_t - {pc, instr} pair as handed from fetch to ID
package dlx_pkg;

   localparam int PC_STEP  = 4;
   localparam int DLX_XLEN = 32;
   localparam int DLX_ILEN = 32;

   typedef struct packed {
      logic [DLX_XLEN-1:0] pc;
      logic [DLX_ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_unit_if.sv
// dlx_fetch_unit_if: instruction ROM request/response bus.
//   i_address    - request address (fetch -> ROM)
//   i_req        - request strobe (fetch -> ROM)
//   i_data_valid - response strobe for the oldest outstanding request (ROM -> fetch)
//   i_data_read  - response data (ROM -> fetch)
// master = fetch unit, slave = ROM.
interface dlx_fetch_unit_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic [XLEN-1:0] i_address;
   logic            i_req;
   logic            i_data_valid;
   logic [ILEN-1:0] i_data_read;

   modport master (output i_address, i_req, input  i_data_valid, i_data_read);
   modport slave  (input  i_address, i_req, output i_data_valid, i_data_read);
endinterface

// File: rtl/dlx_fifo.sv
// dlx_fifo: synchronous FIFO with flush.
//   clk, reset_n - clock, async active-low reset
//   push_i/wdata_i - write one entry (caller guarantees not full)
//   pop_i          - drop head entry (caller guarantees not empty)
//   flush_i        - empty the FIFO; overrides push/pop
//   rdata_o        - head entry (undefined contents when empty)
//   count_o        - number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module dlx_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + 1'b1;
         if (pop_i)  rd_d = rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: count gates every use of the head.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/dlx_fetch_unit.sv
// dlx_fetch_unit: prefetching instruction-fetch stage for the pipelined DLX.
//   clk, reset_n        - clock, async active-low reset
//   rom                 - ROM request/response bus (master side)
//   pc_cmd_ID/pc_in_ID  - redirect from ID
//   pc_cmd_EX/pc_in_EX  - redirect from EX (wins over ID)
//   instr_valid_ID, instr_ID, PC_ID, instr_ready_ID - valid/ready hand-off to ID
// Requests are pipelined up to DEPTH deep; responses land in a DEPTH-entry
// queue. A redirect flushes the queue and marks every still-outstanding
// request for discard, since the ROM cannot cancel them.
module dlx_fetch_unit
   import dlx_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              ILEN     = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   dlx_fetch_unit_if.master      rom,
   input  logic                  pc_cmd_ID,
   input  logic [XLEN-1:0]       pc_in_ID,
   input  logic                  pc_cmd_EX,
   input  logic [XLEN-1:0]       pc_in_EX,
   output logic                  instr_valid_ID,
   output logic [ILEN-1:0]       instr_ID,
   output logic [XLEN-1:0]       PC_ID,
   input  logic                  instr_ready_ID
);
   localparam int              CW      = $clog2(DEPTH+1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]     DEPTH_X = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

   logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]      resp_pc_q, resp_pc_d;
   logic [CW-1:0]        inflight_q, inflight_d;
   logic [CW-1:0]        discard_q, discard_d;
   logic [CW-1:0]        count;
   logic [CW:0]          occ;
   logic [XLEN+ILEN-1:0] head;
   logic                 redirect, issue, rsp, keep, pop, head_vld;
   logic [XLEN-1:0]      target;

   assign redirect = pc_cmd_EX | pc_cmd_ID;
   assign target   = pc_cmd_EX ? pc_in_EX : pc_in_ID;
   assign rsp      = rom.i_data_valid;

   // Slots already promised: queued entries plus responses still to be kept.
   // No same-cycle pop credit, so a push can never hit a full queue.
   assign occ   = {1'b0, count} + {1'b0, inflight_q} - {1'b0, discard_q};
   assign issue = reset_n & ~redirect & (inflight_q < DEPTH_C) & (occ < DEPTH_X);
   assign keep  = rsp & (discard_q == '0) & ~redirect;

   assign head_vld       = (count != '0);
   assign instr_valid_ID = head_vld & ~redirect;
   assign pop            = instr_valid_ID & instr_ready_ID;
   assign instr_ID       = head_vld ? head[ILEN-1:0]         : '0;
   assign PC_ID          = head_vld ? head[XLEN+ILEN-1:ILEN] : '0;

   assign rom.i_req     = issue;
   assign rom.i_address = fetch_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q + CW'(issue) - CW'(rsp);
      discard_d  = discard_q;
      if (redirect) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         // Everything still outstanding after this cycle belongs to the old path.
         discard_d  = inflight_q - CW'(rsp);
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + STEP;
         if (keep)  resp_pc_d  = resp_pc_q + STEP;
         if (rsp && discard_q != '0) discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   dlx_fifo #(
      .WIDTH (XLEN+ILEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (keep),
      .pop_i   (pop),
      .flush_i (redirect),
      .wdata_i ({resp_pc_q, rom.i_data_read}),
      .rdata_o (head),
      .count_o (count)
   );

endmodule

// File: tb/tb_dlx_fetch_unit.sv
module tb_dlx_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        pc_cmd_ID, pc_cmd_EX, instr_ready_ID, instr_valid_ID;
   logic [31:0] pc_in_ID, pc_in_EX, instr_ID, PC_ID;

   dlx_fetch_unit_if #(.XLEN(32), .ILEN(32)) rom_if ();

   dlx_fetch_unit #(
      .XLEN(32), .DEPTH(4), .RESET_PC(32'h100), .ILEN(32)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rom            (rom_if),
      .pc_cmd_ID      (pc_cmd_ID),
      .pc_in_ID       (pc_in_ID),
      .pc_cmd_EX      (pc_cmd_EX),
      .pc_in_EX       (pc_in_EX),
      .instr_valid_ID (instr_valid_ID),
      .instr_ID       (instr_ID),
      .PC_ID          (PC_ID),
      .instr_ready_ID (instr_ready_ID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // ---------------- ROM model: in-order, fixed or random latency ----------------
   int          fixed_lat = 1;
   bit          rand_lat  = 0;
   int          cyc = 0;
   logic [31:0] rq_addr[$];
   int          rq_due[$];
   logic [31:0] rsp_addr[$];
   bit          smp_req, smp_vld;
   logic [31:0] smp_addr;

   always @(negedge clk) begin
      smp_req  = reset_n & rom_if.i_req;
      smp_addr = rom_if.i_address;
      smp_vld  = reset_n & rom_if.i_data_valid;
   end

   initial begin
      rom_if.i_data_valid = 1'b0;
      rom_if.i_data_read  = '0;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            rq_addr.delete();
            rq_due.delete();
         end else begin
            if (smp_vld && rq_addr.size() > 0) begin
               rsp_addr.push_back(rq_addr[0]);
               void'(rq_addr.pop_front());
               void'(rq_due.pop_front());
            end
            if (smp_req) begin
               rq_addr.push_back(smp_addr);
               rq_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 5)) : fixed_lat));
            end
         end
         cyc++;
         #1;
         if (reset_n && rq_addr.size() > 0 && rq_due[0] <= cyc) begin
            rom_if.i_data_valid = 1'b1;
            rom_if.i_data_read  = rom_word(rq_addr[0]);
         end else begin
            rom_if.i_data_valid = 1'b0;
            rom_if.i_data_read  = '0;
         end
      end
   end

   // ---------------- monitors ----------------
   logic [31:0] dlv_pc[$], dlv_in[$], req_addr[$];

   always @(negedge clk) begin
      if (reset_n) begin
         if (instr_valid_ID && instr_ready_ID) begin
            dlv_pc.push_back(PC_ID);
            dlv_in.push_back(instr_ID);
         end
         if (rom_if.i_req) req_addr.push_back(rom_if.i_address);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_logs();
      dlv_pc.delete();
      dlv_in.delete();
      req_addr.delete();
      rsp_addr.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      clr_logs();
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int bad;
      reset_n = 1'b1; pc_cmd_ID = 0; pc_cmd_EX = 0; pc_in_ID = 0; pc_in_EX = 0;
      instr_ready_ID = 0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_req",   rom_if.i_req,     0);
      chk("rst_addr",  rom_if.i_address, 32'h100);
      chk("rst_valid", instr_valid_ID,   0);
      chk("rst_instr", instr_ID,         0);
      chk("rst_pc",    PC_ID,            0);

      // Sequential fetch, 1-cycle ROM, ID always ready
      instr_ready_ID = 1;
      tick(); tick();
      clr_logs();
      reset_n = 1'b1;
      sample();
      chk("seq_req0",  rom_if.i_req,     1);
      chk("seq_addr0", rom_if.i_address, 32'h100);
      tick(); sample();
      chk("seq_addr1", rom_if.i_address, 32'h104);
      chk("seq_vld1",  instr_valid_ID,   0);
      tick(); sample();
      chk("seq_addr2", rom_if.i_address, 32'h108);
      chk("seq_vld2",  instr_valid_ID,   1);
      chk("seq_pc2",   PC_ID,            32'h100);
      chk("seq_ins2",  instr_ID,         32'hFEFF_0100);
      tick(); sample();
      chk("seq_pc3",   PC_ID,            32'h104);

      // Back-pressure: queue fills, exactly DEPTH requests
      instr_ready_ID = 0;
      do_reset();
      repeat (8) tick();
      sample();
      chk("bp_nreq",  req_addr.size(), 4);
      chk("bp_req",   rom_if.i_req,    0);
      chk("bp_pc",    PC_ID,           32'h100);
      tick(); instr_ready_ID = 1; sample();
      chk("bp_vld",   instr_valid_ID,  1);
      chk("bp_nocr",  rom_if.i_req,    0);
      tick(); instr_ready_ID = 0; sample();
      chk("bp_req1",  rom_if.i_req,     1);
      chk("bp_addr1", rom_if.i_address, 32'h110);
      chk("bp_pc1",   PC_ID,            32'h104);
      repeat (4) tick();
      sample();
      chk("bp_nreq1", req_addr.size(), 5);

      // EX redirect with 3 requests outstanding, 3-cycle ROM
      fixed_lat = 3; instr_ready_ID = 1;
      do_reset();
      repeat (3) tick();
      clr_logs();
      pc_cmd_EX = 1; pc_in_EX = 32'h200;
      sample();
      chk("ex_req",   rom_if.i_req, 0);
      tick(); pc_cmd_EX = 0; sample();
      chk("ex_req1",  rom_if.i_req,     1);
      chk("ex_addr1", rom_if.i_address, 32'h200);
      repeat (12) tick();
      sample();
      chk("ex_ndlv", dlv_pc.size() >= 3, 1);
      bad = 0;
      foreach (dlv_pc[k]) begin
         if (dlv_pc[k] != 32'h200 + 32'(4*k) || dlv_in[k] != rom_word(dlv_pc[k])) bad++;
      end
      chk("ex_stream", bad, 0);
      bad = 0;
      foreach (rsp_addr[k]) if (rsp_addr[k] < 32'h200) bad++;
      chk("ex_stale", bad, 3);

      // Simultaneous ID and EX redirect: EX wins, head nullified
      fixed_lat = 1;
      do_reset();
      repeat (5) tick();
      clr_logs();
      pc_cmd_ID = 1; pc_in_ID = 32'h300; pc_cmd_EX = 1; pc_in_EX = 32'h400;
      sample();
      chk("both_vld", instr_valid_ID, 0);
      chk("both_req", rom_if.i_req,   0);
      tick(); pc_cmd_ID = 0; pc_cmd_EX = 0; sample();
      chk("both_addr", rom_if.i_address, 32'h400);
      repeat (4) tick();
      sample();
      chk("both_pc", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hFFFF_FFFF, 32'h400);

      // Random latency and random ready: contiguous, lossless stream
      rand_lat = 1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         instr_ready_ID = 1'($urandom_range(0, 1));
         tick();
      end
      sample();
      chk("rnd_ndlv", dlv_pc.size() > 50, 1);
      bad = 0;
      foreach (dlv_pc[k]) begin
         if (dlv_pc[k] != 32'h100 + 32'(4*k) || dlv_in[k] != rom_word(dlv_pc[k])) bad++;
      end
      chk("rnd_stream", bad, 0);
      rand_lat = 0;

      // Reset asserted mid-stream with a full queue
      fixed_lat = 1; instr_ready_ID = 0;
      do_reset();
      repeat (8) tick();
      sample();
      chk("mr_full", instr_valid_ID, 1);
      tick();
      reset_n = 1'b0;
      #1;
      chk("mr_req",   rom_if.i_req,     0);
      chk("mr_addr",  rom_if.i_address, 32'h100);
      chk("mr_vld",   instr_valid_ID,   0);
      chk("mr_instr", instr_ID,         0);
      chk("mr_pc",    PC_ID,            0);
      tick();
      clr_logs();
      reset_n = 1'b1;
      sample();
      chk("mr_req1",  rom_if.i_req,     1);
      chk("mr_addr1", rom_if.i_address, 32'h100);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
